// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM: one byte-enabled write port and one independent read port.
// Read latency is 1 cycle, or 2 cycles when OUT_REG=1. Writes take effect at the clock edge.
// There is no back-pressure: every accepted read produces exactly one rd_valid pulse.
module ram_sdp_be #(
    parameter  int DATA_WIDTH = 32,
    parameter  int BYTE_WIDTH = 8,
    parameter  int DEPTH      = 256,
    parameter  int RDW_MODE   = 0,
    parameter  int OUT_REG    = 0,
    localparam int ADDR_BITS  = $clog2(DEPTH),
    localparam int NB         = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [NB-1:0]         wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    // Reject parameter combinations that cannot be built.
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_err_width
        $error("ram_sdp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (DEPTH < 2) begin : g_err_depth
        $error("ram_sdp_be: DEPTH must be at least 2");
    end
    if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_err_rdw
        $error("ram_sdp_be: RDW_MODE must be 0 or 1");
    end
    if (OUT_REG != 0 && OUT_REG != 1) begin : g_err_oreg
        $error("ram_sdp_be: OUT_REG must be 0 or 1");
    end

    // One extra bit so that DEPTH itself is representable for the range compare.
    localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_ok;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    // Out-of-range addresses are dropped rather than wrapped, so DEPTH need not be a power of two.
    assign wr_ok       = wr_en && !reset && ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

    // Byte-lane write into the array; disabled lanes keep their contents.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read word selection: zero when out of range, write-first lane bypass on a same-address collision.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
            if (RDW_MODE == 0 && wr_en && (wr_addr == rd_addr)) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_be[i]) begin
                        rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // First read stage: data only loads on an accepted read so the output holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                s1_data <= rd_word;
            end
        end
    end

    if (OUT_REG == 1) begin : g_out_reg
        logic                  s2_valid;
        logic [DATA_WIDTH-1:0] s2_data;

        // Optional output stage, loaded only when the first stage carries a result.
        always_ff @(posedge clk) begin
            if (reset) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign rd_data  = s2_data;
        assign rd_valid = s2_valid;
    end else begin : g_no_out_reg
        assign rd_data  = s1_data;
        assign rd_valid = s1_valid;
    end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench for ram_sdp_be: two instances driven in lock-step.
// Instance a: write-first, latency 1. Instance b: read-first, latency 2. Both DEPTH=200.
// Every result is compared against hand-computed constants.
module tb_ram_sdp_be;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] a_data;
    logic        a_valid;
    logic [31:0] b_data;
    logic        b_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_sdp_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(200), .RDW_MODE(0), .OUT_REG(0)) dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_data), .rd_valid(a_valid)
    );

    ram_sdp_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(200), .RDW_MODE(1), .OUT_REG(1)) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_data), .rd_valid(b_valid)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_be = be;
        cyc();
        wr_en = 1'b0;
    endtask

    // Issues one read (with whatever write is already set up) and captures both instances' results.
    task automatic do_read(input logic [7:0] addr,
                           output logic [31:0] ad, output logic av, output logic a_late,
                           output logic [31:0] bd, output logic bv, output logic b_early);
        rd_en = 1'b1; rd_addr = addr;
        cyc();
        rd_en = 1'b0; wr_en = 1'b0;
        ad = a_data; av = a_valid; b_early = b_valid;
        cyc();
        bd = b_data; bv = b_valid; a_late = a_valid;
    endtask

    task automatic test_reset();
        logic [31:0] ad, bd;
        logic av, bv, al, be;
        reset = 1'b1; rd_en = 1'b1; rd_addr = 8'd5;
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        for (int c = 0; c < 3; c++) begin
            cyc();
            total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset a_valid cyc%0d got=%b exp=0", c, a_valid); end
            total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL reset b_valid cyc%0d got=%b exp=0", c, b_valid); end
            total++; if (a_data !== 32'h0) begin bad++; $display("FAIL reset a_data cyc%0d got=%h exp=0", c, a_data); end
            total++; if (b_data !== 32'h0) begin bad++; $display("FAIL reset b_data cyc%0d got=%h exp=0", c, b_data); end
        end
        reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        cyc();
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL post_reset a_valid got=%b exp=0", a_valid); end
        total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL post_reset b_valid got=%b exp=0", b_valid); end
        do_read(8'd5, ad, av, al, bd, bv, be);
        total++; if (av !== 1'b1) begin bad++; $display("FAIL suppressed_wr a_valid got=%b exp=1", av); end
        total++; if (ad === 32'hDEADBEEF) begin bad++; $display("FAIL suppressed_wr a_data got=%h exp=not deadbeef", ad); end
        total++; if (bd === 32'hDEADBEEF) begin bad++; $display("FAIL suppressed_wr b_data got=%h exp=not deadbeef", bd); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] ad, bd;
        logic av, bv, al, be;
        wr(8'd3, 32'h11223344, 4'hF);
        wr(8'd3, 32'hAABBCCDD, 4'h5);
        do_read(8'd3, ad, av, al, bd, bv, be);
        total++; if (ad !== 32'h11BB33DD) begin bad++; $display("FAIL be_merge a_data got=%h exp=11bb33dd", ad); end
        total++; if (av !== 1'b1) begin bad++; $display("FAIL be_lat1 a_valid got=%b exp=1", av); end
        total++; if (be !== 1'b0) begin bad++; $display("FAIL be_lat2 b_valid_early got=%b exp=0", be); end
        total++; if (bd !== 32'h11BB33DD) begin bad++; $display("FAIL be_merge b_data got=%h exp=11bb33dd", bd); end
        total++; if (bv !== 1'b1) begin bad++; $display("FAIL be_lat2 b_valid got=%b exp=1", bv); end
        total++; if (al !== 1'b0) begin bad++; $display("FAIL be_pulse a_valid_late got=%b exp=0", al); end
        total++; if (a_data !== 32'h11BB33DD) begin bad++; $display("FAIL be_hold a_data got=%h exp=11bb33dd", a_data); end
    endtask

    task automatic test_collision();
        logic [31:0] ad, bd;
        logic av, bv, al, be;
        wr(8'd7, 32'h00000000, 4'hF);
        wr_en = 1'b1; wr_addr = 8'd7; wr_data = 32'hCAFEF00D; wr_be = 4'h3;
        do_read(8'd7, ad, av, al, bd, bv, be);
        total++; if (ad !== 32'h0000F00D) begin bad++; $display("FAIL coll_wf a_data got=%h exp=0000f00d", ad); end
        total++; if (bd !== 32'h00000000) begin bad++; $display("FAIL coll_rf b_data got=%h exp=00000000", bd); end
        total++; if (bv !== 1'b1) begin bad++; $display("FAIL coll_rf b_valid got=%b exp=1", bv); end
        do_read(8'd7, ad, av, al, bd, bv, be);
        total++; if (ad !== 32'h0000F00D) begin bad++; $display("FAIL coll_after a_data got=%h exp=0000f00d", ad); end
        total++; if (bd !== 32'h0000F00D) begin bad++; $display("FAIL coll_after b_data got=%h exp=0000f00d", bd); end
        // Collision with no lanes enabled returns the stored word in both modes.
        wr_en = 1'b1; wr_addr = 8'd7; wr_data = 32'hFFFFFFFF; wr_be = 4'h0;
        do_read(8'd7, ad, av, al, bd, bv, be);
        total++; if (ad !== 32'h0000F00D) begin bad++; $display("FAIL coll_be0 a_data got=%h exp=0000f00d", ad); end
        total++; if (bd !== 32'h0000F00D) begin bad++; $display("FAIL coll_be0 b_data got=%h exp=0000f00d", bd); end
        // Simultaneous write to a different address does not disturb the read.
        wr_en = 1'b1; wr_addr = 8'd4; wr_data = 32'h44444444; wr_be = 4'hF;
        do_read(8'd3, ad, av, al, bd, bv, be);
        total++; if (ad !== 32'h11BB33DD) begin bad++; $display("FAIL nocoll a_data got=%h exp=11bb33dd", ad); end
        total++; if (bd !== 32'h11BB33DD) begin bad++; $display("FAIL nocoll b_data got=%h exp=11bb33dd", bd); end
        do_read(8'd4, ad, av, al, bd, bv, be);
        total++; if (ad !== 32'h44444444) begin bad++; $display("FAIL nocoll_wr a_data got=%h exp=44444444", ad); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) begin
            wr(8'(k), 32'(k) * 32'h01010101, 4'hF);
        end
        for (int i = 0; i <= 16; i++) begin
            rd_en = (i < 16); rd_addr = 8'(i);
            cyc();
            if (i < 16) begin
                total++; if (a_valid !== 1'b1 || a_data !== 32'(i) * 32'h01010101) begin
                    bad++; $display("FAIL stream_a idx%0d got=%b/%h exp=1/%h", i, a_valid, a_data, 32'(i) * 32'h01010101);
                end
            end
            if (i >= 1) begin
                total++; if (b_valid !== 1'b1 || b_data !== 32'(i - 1) * 32'h01010101) begin
                    bad++; $display("FAIL stream_b idx%0d got=%b/%h exp=1/%h", i - 1, b_valid, b_data, 32'(i - 1) * 32'h01010101);
                end
            end else begin
                total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL stream_b_first got=%b exp=0", b_valid); end
            end
        end
        rd_en = 1'b0;
        cyc();
        total++; if (a_valid !== 1'b0 || a_data !== 32'h0F0F0F0F) begin bad++; $display("FAIL idle_hold_a got=%b/%h exp=0/0f0f0f0f", a_valid, a_data); end
        total++; if (b_valid !== 1'b0 || b_data !== 32'h0F0F0F0F) begin bad++; $display("FAIL idle_hold_b got=%b/%h exp=0/0f0f0f0f", b_valid, b_data); end
    endtask

    task automatic test_reset_mid();
        rd_en = 1'b1; rd_addr = 8'd1;
        cyc();
        total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL mid_rst stage1 b_valid got=%b exp=0", b_valid); end
        rd_addr = 8'd2; reset = 1'b1;
        cyc();
        reset = 1'b0; rd_en = 1'b0;
        total++; if (b_valid !== 1'b0 || b_data !== 32'h0) begin bad++; $display("FAIL mid_rst b got=%b/%h exp=0/0", b_valid, b_data); end
        total++; if (a_valid !== 1'b0 || a_data !== 32'h0) begin bad++; $display("FAIL mid_rst a got=%b/%h exp=0/0", a_valid, a_data); end
        for (int c = 0; c < 2; c++) begin
            cyc();
            total++; if (b_valid !== 1'b0 || b_data !== 32'h0) begin bad++; $display("FAIL mid_rst squash cyc%0d got=%b/%h exp=0/0", c, b_valid, b_data); end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] ad, bd;
        logic av, bv, al, be;
        wr(8'd82, 32'h52525252, 4'hF);
        wr(8'd210, 32'hFFFFFFFF, 4'hF);
        do_read(8'd210, ad, av, al, bd, bv, be);
        total++; if (av !== 1'b1 || ad !== 32'h0) begin bad++; $display("FAIL oor_a got=%b/%h exp=1/0", av, ad); end
        total++; if (bv !== 1'b1 || bd !== 32'h0) begin bad++; $display("FAIL oor_b got=%b/%h exp=1/0", bv, bd); end
        do_read(8'd10, ad, av, al, bd, bv, be);
        total++; if (ad !== 32'h0A0A0A0A) begin bad++; $display("FAIL alias10 a_data got=%h exp=0a0a0a0a", ad); end
        total++; if (bd !== 32'h0A0A0A0A) begin bad++; $display("FAIL alias10 b_data got=%h exp=0a0a0a0a", bd); end
        do_read(8'd82, ad, av, al, bd, bv, be);
        total++; if (ad !== 32'h52525252) begin bad++; $display("FAIL alias82 a_data got=%h exp=52525252", ad); end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        test_reset();
        test_byte_enable();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
